// File: rtl/axis_filter_frame_arbiter.sv
// Two-requester round-robin arbiter that shares one averaging filter.
// One frame is in flight at a time; a filter timeout discards the frame.
module axis_filter_frame_arbiter #(
  parameter int DATA_W         = 392,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s0_valid,
  output logic              s0_ready,
  input  logic [DATA_W-1:0] s0_data,
  input  logic              s1_valid,
  output logic              s1_ready,
  input  logic [DATA_W-1:0] s1_data,
  output logic              m_flt_valid,
  input  logic              m_flt_ready,
  output logic [DATA_W-1:0] m_flt_data,
  input  logic              s_flt_valid,
  output logic              s_flt_ready,
  input  logic [DATA_W-1:0] s_flt_data,
  output logic              m0_valid,
  input  logic              m0_ready,
  output logic [DATA_W-1:0] m0_data,
  output logic              m1_valid,
  input  logic              m1_ready,
  output logic [DATA_W-1:0] m1_data,
  output logic              busy,
  output logic              grant_id,
  output logic [15:0]       frame_count,
  output logic              timeout_err
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ISSUE  = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;
  localparam logic [1:0] ST_RETURN = 2'd3;

  localparam int              TW     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0]   T_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [1:0]        state;
  logic [DATA_W-1:0] frame_reg;
  logic [DATA_W-1:0] result_reg;
  logic              grant_id_q;
  logic              last_served;
  logic [15:0]       frame_cnt_q;
  logic [TW-1:0]     tcount;

  logic req_sel;
  logic accept;
  logic flt_done;
  logic timeout_hit;
  logic ret_done;

  // On a tie the requester that was not served last wins.
  always_comb begin
    req_sel = s1_valid;
    if (s0_valid && s1_valid) begin
      req_sel = ~last_served;
    end
  end

  assign s0_ready    = (state == ST_IDLE) && s0_valid && !req_sel;
  assign s1_ready    = (state == ST_IDLE) && s1_valid && req_sel;
  assign accept      = (s0_valid && s0_ready) || (s1_valid && s1_ready);

  assign m_flt_valid = (state == ST_ISSUE);
  assign m_flt_data  = frame_reg;
  assign s_flt_ready = (state == ST_WAIT);

  // A result on the final waiting cycle beats the timeout.
  assign flt_done    = (state == ST_WAIT) && s_flt_valid;
  assign timeout_hit = (state == ST_WAIT) && !s_flt_valid && (tcount == T_LAST);

  assign m0_valid    = (state == ST_RETURN) && !grant_id_q;
  assign m1_valid    = (state == ST_RETURN) && grant_id_q;
  assign m0_data     = result_reg;
  assign m1_data     = result_reg;
  assign ret_done    = (m0_valid && m0_ready) || (m1_valid && m1_ready);

  assign busy        = (state != ST_IDLE);
  assign grant_id    = grant_id_q;
  assign frame_count = frame_cnt_q;
  assign timeout_err = timeout_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      grant_id_q  <= 1'b0;
      last_served <= 1'b1;
      frame_cnt_q <= 16'd0;
      tcount      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state      <= ST_ISSUE;
            grant_id_q <= req_sel;
          end
        end
        ST_ISSUE: begin
          if (m_flt_ready) begin
            state  <= ST_WAIT;
            tcount <= '0;
          end
        end
        ST_WAIT: begin
          if (s_flt_valid) begin
            state <= ST_RETURN;
          end else if (timeout_hit) begin
            state       <= ST_IDLE;
            last_served <= grant_id_q;
          end else begin
            tcount <= tcount + TW'(1);
          end
        end
        ST_RETURN: begin
          if (ret_done) begin
            state       <= ST_IDLE;
            frame_cnt_q <= frame_cnt_q + 16'd1;
            last_served <= grant_id_q;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Frame and result storage carry no reset; they are only read once loaded.
  always_ff @(posedge clk) begin
    if (accept) begin
      frame_reg <= req_sel ? s1_data : s0_data;
    end
    if (flt_done) begin
      result_reg <= s_flt_data;
    end
  end

endmodule

// File: tb/tb_axis_filter_frame_arbiter.sv
// Bench for axis_filter_frame_arbiter: a per-cycle vector table, directed corner
// sequences, then random traffic scored against a transaction-level model.
module tb_axis_filter_frame_arbiter;

  localparam int DW = 392;
  localparam int TO = 16;
  localparam logic [DW-1:0] PAT_A5 = {49{8'hA5}};
  localparam logic [DW-1:0] PAT_3C = {49{8'h3C}};
  localparam logic [DW-1:0] PAT_5A = {49{8'h5A}};

  logic          clk = 1'b0;
  logic          rst;
  logic          s0_valid, s0_ready, s1_valid, s1_ready;
  logic [DW-1:0] s0_data, s1_data;
  logic          m_flt_valid, m_flt_ready, s_flt_valid, s_flt_ready;
  logic [DW-1:0] m_flt_data, s_flt_data;
  logic          m0_valid, m0_ready, m1_valid, m1_ready;
  logic [DW-1:0] m0_data, m1_data;
  logic          busy, grant_id, timeout_err;
  logic [15:0]   frame_count;

  int n_cmp = 0;
  int n_err = 0;

  axis_filter_frame_arbiter #(.DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_data(s0_data),
    .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_data(s1_data),
    .m_flt_valid(m_flt_valid), .m_flt_ready(m_flt_ready), .m_flt_data(m_flt_data),
    .s_flt_valid(s_flt_valid), .s_flt_ready(s_flt_ready), .s_flt_data(s_flt_data),
    .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_data(m0_data),
    .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_data(m1_data),
    .busy(busy), .grant_id(grant_id), .frame_count(frame_count),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rst, s0_v, s1_v, mflt_r, sflt_v, m0_r, m1_r;
    logic s0_rdy, s1_rdy, mflt_v, sflt_rdy, m0_v, m1_v, busy, gid, terr;
    logic [15:0] fc;
  } vec_t;

  vec_t vecs[15];

  task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic checkFlag(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    rst         = v.rst;
    s0_valid    = v.s0_v;
    s1_valid    = v.s1_v;
    m_flt_ready = v.mflt_r;
    s_flt_valid = v.sflt_v;
    m0_ready    = v.m0_r;
    m1_ready    = v.m1_r;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    s0_valid = 0; s1_valid = 0; m_flt_ready = 0; s_flt_valid = 0;
    m0_ready = 0; m1_ready = 0;
    s0_data = PAT_A5; s1_data = PAT_3C; s_flt_data = PAT_5A;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic logic [DW-1:0] rand_frame();
    logic [DW-1:0] d = '0;
    for (int k = 0; k < (DW + 31) / 32; k++) d = {d[DW-33:0], 32'($urandom())};
    return d;
  endfunction

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic          m1_seen;
    int            n_to, hits;
    int            ph, age, delay;
    logic          owner, last_m, gid_m, g, any, acc0, acc1, exp_to;
    logic [15:0]   fc_m;
    logic [DW-1:0] frame_m, result_m;

    //             rst s0 s1 mfr sfv m0r m1r | s0r s1r mfv sfr m0v m1v bsy gid ter fc
    vecs[0]  = '{0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0, 16'd0};
    vecs[1]  = '{0, 1, 1, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0, 0, 0, 16'd0};
    vecs[2]  = '{0, 0, 1, 0, 0, 0, 0,   0, 0, 1, 0, 0, 0, 1, 0, 0, 16'd0};
    vecs[3]  = '{0, 0, 1, 1, 0, 0, 0,   0, 0, 1, 0, 0, 0, 1, 0, 0, 16'd0};
    vecs[4]  = '{0, 0, 1, 0, 0, 0, 0,   0, 0, 0, 1, 0, 0, 1, 0, 0, 16'd0};
    vecs[5]  = '{0, 0, 1, 0, 1, 0, 0,   0, 0, 0, 1, 0, 0, 1, 0, 0, 16'd0};
    vecs[6]  = '{0, 0, 1, 0, 0, 0, 0,   0, 0, 0, 0, 1, 0, 1, 0, 0, 16'd0};
    vecs[7]  = '{0, 0, 1, 0, 0, 1, 0,   0, 0, 0, 0, 1, 0, 1, 0, 0, 16'd0};
    vecs[8]  = '{0, 0, 1, 0, 0, 0, 0,   0, 1, 0, 0, 0, 0, 0, 0, 0, 16'd1};
    vecs[9]  = '{0, 0, 0, 1, 0, 0, 0,   0, 0, 1, 0, 0, 0, 1, 1, 0, 16'd1};
    vecs[10] = '{0, 0, 0, 0, 1, 0, 0,   0, 0, 0, 1, 0, 0, 1, 1, 0, 16'd1};
    vecs[11] = '{0, 0, 0, 0, 0, 1, 1,   0, 0, 0, 0, 0, 1, 1, 1, 0, 16'd1};
    vecs[12] = '{0, 1, 1, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0, 1, 0, 16'd2};
    vecs[13] = '{1, 0, 0, 0, 0, 0, 0,   0, 0, 1, 0, 0, 0, 1, 0, 0, 16'd2};
    vecs[14] = '{0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0, 16'd0};

    do_reset();
    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i]);
      #1;
      checkFlag($sformatf("vec%0d_s0_ready", i), s0_ready, vecs[i].s0_rdy);
      checkFlag($sformatf("vec%0d_s1_ready", i), s1_ready, vecs[i].s1_rdy);
      checkFlag($sformatf("vec%0d_m_flt_valid", i), m_flt_valid, vecs[i].mflt_v);
      checkFlag($sformatf("vec%0d_s_flt_ready", i), s_flt_ready, vecs[i].sflt_rdy);
      checkFlag($sformatf("vec%0d_m0_valid", i), m0_valid, vecs[i].m0_v);
      checkFlag($sformatf("vec%0d_m1_valid", i), m1_valid, vecs[i].m1_v);
      checkFlag($sformatf("vec%0d_busy", i), busy, vecs[i].busy);
      checkFlag($sformatf("vec%0d_grant_id", i), grant_id, vecs[i].gid);
      checkFlag($sformatf("vec%0d_timeout_err", i), timeout_err, vecs[i].terr);
      checkOutput($sformatf("vec%0d_frame_count", i), DW'(frame_count), DW'(vecs[i].fc));
      @(negedge clk);
    end

    // Single request with the filter echoing after ten cycles.
    do_reset();
    s0_valid = 1; s0_data = PAT_A5;
    #1 checkFlag("single_s0_ready", s0_ready, 1'b1);
    @(negedge clk);
    s0_valid = 0; m_flt_ready = 1;
    #1 checkFlag("single_m_flt_valid", m_flt_valid, 1'b1);
    checkOutput("single_m_flt_data", m_flt_data, PAT_A5);
    @(negedge clk);
    m_flt_ready = 0; m1_seen = 0;
    repeat (10) begin
      #1 if (m1_valid) m1_seen = 1;
      @(negedge clk);
    end
    s_flt_valid = 1; s_flt_data = PAT_A5;
    #1 checkFlag("single_s_flt_ready", s_flt_ready, 1'b1);
    @(negedge clk);
    s_flt_valid = 0; m0_ready = 1;
    #1 checkFlag("single_m0_valid", m0_valid, 1'b1);
    checkOutput("single_m0_data", m0_data, PAT_A5);
    if (m1_valid) m1_seen = 1;
    @(negedge clk);
    m0_ready = 0;
    #1 checkFlag("single_m1_never", m1_seen | m1_valid, 1'b0);
    checkFlag("single_busy_after", busy, 1'b0);
    checkOutput("single_frame_count", DW'(frame_count), DW'(16'd1));
    @(negedge clk);

    // Backpressure on the filter input and on the return path.
    s0_valid = 1; s0_data = PAT_3C;
    #1 checkFlag("bp_s0_ready", s0_ready, 1'b1);
    @(negedge clk);
    s0_valid = 0; m_flt_ready = 0;
    for (int i = 0; i < 5; i++) begin
      #1 checkFlag($sformatf("bp_issue%0d_valid", i), m_flt_valid, 1'b1);
      checkOutput($sformatf("bp_issue%0d_data", i), m_flt_data, PAT_3C);
      @(negedge clk);
    end
    m_flt_ready = 1;
    #1 checkOutput("bp_issue_final_data", m_flt_data, PAT_3C);
    @(negedge clk);
    m_flt_ready = 0; s_flt_valid = 1; s_flt_data = PAT_5A;
    @(negedge clk);
    s_flt_valid = 0; m0_ready = 0;
    for (int i = 0; i < 7; i++) begin
      #1 checkFlag($sformatf("bp_ret%0d_valid", i), m0_valid, 1'b1);
      checkOutput($sformatf("bp_ret%0d_data", i), m0_data, PAT_5A);
      checkOutput($sformatf("bp_ret%0d_count", i), DW'(frame_count), DW'(16'd1));
      @(negedge clk);
    end
    m0_ready = 1;
    #1 checkOutput("bp_m1_data_shared", m1_data, PAT_5A);
    checkFlag("bp_m1_valid", m1_valid, 1'b0);
    @(negedge clk);
    m0_ready = 0;
    #1 checkOutput("bp_count_once", DW'(frame_count), DW'(16'd2));
    checkFlag("bp_busy_after", busy, 1'b0);
    @(negedge clk);

    // Filter never answers: pulse sixteen cycles after the filter handshake.
    do_reset();
    s0_valid = 1; s1_valid = 1;
    #1 checkFlag("to_first_tie_s0", s0_ready, 1'b1);
    @(negedge clk);
    s0_valid = 0; s1_valid = 0; m_flt_ready = 1;
    @(negedge clk);
    m_flt_ready = 0; n_to = 0; hits = 0;
    for (int c = 1; c <= 40; c++) begin
      #1 if (timeout_err) begin
        hits++;
        if (n_to == 0) n_to = c;
      end
      @(negedge clk);
    end
    checkOutput("to_cycle", DW'(n_to), DW'(TO));
    checkOutput("to_pulses", DW'(hits), DW'(1));
    #1 checkFlag("to_busy", busy, 1'b0);
    checkOutput("to_frame_count", DW'(frame_count), DW'(16'd0));
    s0_valid = 1; s1_valid = 1;
    #1 checkFlag("to_next_tie_s1", s1_ready, 1'b1);
    checkFlag("to_next_tie_s0", s0_ready, 1'b0);
    @(negedge clk);

    // Reset while waiting on the filter; the late result must be left alone.
    do_reset();
    s0_valid = 1;
    @(negedge clk);
    s0_valid = 0; m_flt_ready = 1;
    @(negedge clk);
    m_flt_ready = 0;
    #1 checkFlag("rw_in_wait", s_flt_ready, 1'b1);
    rst = 1; s_flt_valid = 1; s_flt_data = PAT_A5;
    @(negedge clk);
    rst = 0;
    #1 checkFlag("rw_s_flt_ready", s_flt_ready, 1'b0);
    checkFlag("rw_busy", busy, 1'b0);
    checkFlag("rw_m_flt_valid", m_flt_valid, 1'b0);
    checkFlag("rw_m0_valid", m0_valid, 1'b0);
    checkFlag("rw_m1_valid", m1_valid, 1'b0);
    checkFlag("rw_grant_id", grant_id, 1'b0);
    checkFlag("rw_timeout_err", timeout_err, 1'b0);
    @(negedge clk);
    #1 checkFlag("rw_no_return", m0_valid, 1'b0);
    s_flt_valid = 0;
    @(negedge clk);

    // Completion counter wraps from all-ones to zero.
    do_reset();
    force dut.frame_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.frame_cnt_q;
    #1 checkOutput("wrap_preload", DW'(frame_count), DW'(16'hFFFF));
    s1_valid = 1;
    @(negedge clk);
    s1_valid = 0; m_flt_ready = 1;
    @(negedge clk);
    m_flt_ready = 0; s_flt_valid = 1;
    @(negedge clk);
    s_flt_valid = 0; m1_ready = 1;
    @(negedge clk);
    m1_ready = 0;
    #1 checkOutput("wrap_zero", DW'(frame_count), DW'(16'h0000));
    @(negedge clk);

    // Random traffic against a transaction-level model.
    do_reset();
    ph = 0; age = 0; delay = 1; owner = 0; last_m = 1; gid_m = 0; fc_m = 0;
    frame_m = '0; result_m = '0; acc0 = 0; acc1 = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (acc0 || !s0_valid) begin
        s0_valid = ($urandom_range(0, 2) == 0);
        s0_data  = rand_frame();
      end
      if (acc1 || !s1_valid) begin
        s1_valid = ($urandom_range(0, 2) == 0);
        s1_data  = rand_frame();
      end
      m_flt_ready = ($urandom_range(0, 3) != 0);
      m0_ready    = ($urandom_range(0, 1) == 0);
      m1_ready    = ($urandom_range(0, 1) == 0);
      if (ph == 2) begin
        age++;
        s_flt_valid = (age >= delay);
        s_flt_data  = ~frame_m;
      end else begin
        s_flt_valid = ($urandom_range(0, 4) == 0);
        s_flt_data  = rand_frame();
      end
      #1;
      any    = s0_valid | s1_valid;
      g      = (s0_valid && s1_valid) ? ~last_m : s1_valid;
      exp_to = (ph == 2) && (age == TO) && !s_flt_valid;
      checkFlag("rnd_s0_ready", s0_ready, (ph == 0) && s0_valid && !g);
      checkFlag("rnd_s1_ready", s1_ready, (ph == 0) && s1_valid && g);
      checkFlag("rnd_busy", busy, ph != 0);
      checkFlag("rnd_m_flt_valid", m_flt_valid, ph == 1);
      checkFlag("rnd_s_flt_ready", s_flt_ready, ph == 2);
      checkFlag("rnd_m0_valid", m0_valid, (ph == 3) && !owner);
      checkFlag("rnd_m1_valid", m1_valid, (ph == 3) && owner);
      checkFlag("rnd_timeout_err", timeout_err, exp_to);
      checkFlag("rnd_grant_id", grant_id, gid_m);
      checkOutput("rnd_frame_count", DW'(frame_count), DW'(fc_m));
      if (ph == 1) checkOutput("rnd_m_flt_data", m_flt_data, frame_m);
      if (ph == 3) checkOutput(owner ? "rnd_m1_data" : "rnd_m0_data", owner ? m1_data : m0_data, result_m);
      acc0 = s0_valid && s0_ready;
      acc1 = s1_valid && s1_ready;
      case (ph)
        0: if (any) begin
             owner = g; gid_m = g; frame_m = g ? s1_data : s0_data; ph = 1;
           end
        1: if (m_flt_ready) begin
             ph = 2; age = 0; delay = $urandom_range(1, 20);
           end
        2: if (s_flt_valid) begin
             result_m = s_flt_data; ph = 3;
           end else if (age == TO) begin
             last_m = owner; ph = 0;
           end
        default: if ((!owner && m0_ready) || (owner && m1_ready)) begin
             fc_m = fc_m + 16'd1; last_m = owner; ph = 0;
           end
      endcase
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/axis_filter_frame_arbiter.md
AXIS_FILTER_FRAME_ARBITER -- requirements
Module: axis_filter_frame_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 392, meaning frame width in bits (R_I*C_I*W_I = 7*7*8).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 4096, meaning max cycles to wait for a filter result.
REQ-003 SHALL have port clk  input  1  system clock; one clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports s0_valid/s0_ready/s0_data  in/out/in  1/1/DATA_W  requester 0 frame input (AXI-Stream slave).
REQ-006 SHALL have ports s1_valid/s1_ready/s1_data  in/out/in  1/1/DATA_W  requester 1 frame input (AXI-Stream slave).
REQ-007 SHALL have ports m_flt_valid/m_flt_ready/m_flt_data  out/in/out  1/1/DATA_W  frame to the shared averaging filter.
REQ-008 SHALL have ports s_flt_valid/s_flt_ready/s_flt_data  in/out/in  1/1/DATA_W  filtered frame from the filter.
REQ-009 SHALL have ports m0_valid/m0_ready/m0_data  out/in/out  1/1/DATA_W  result return to requester 0.
REQ-010 SHALL have ports m1_valid/m1_ready/m1_data  out/in/out  1/1/DATA_W  result return to requester 1.
REQ-011 SHALL have port busy  output  1  high whenever state != IDLE.
REQ-012 SHALL have port grant_id  output  1  requester owning the current transaction.
REQ-013 SHALL have port frame_count  output  16  count of completed frames.
REQ-014 SHALL have port timeout_err  output  1  one-cycle pulse on filter timeout.

Function
REQ-015 SHALL implement FSM states IDLE, ISSUE, WAIT, RETURN; a transfer occurs on any cycle where valid and ready are both high.
REQ-016 IDLE: SHALL grant round-robin; if only one sX_valid is high, grant it; if both, grant the requester other than last_served; last_served resets to 1, so s0 wins the first tie.
REQ-017 IDLE: sX_ready SHALL be combinationally high only for the granted requester; on transfer, latch sX_data into frame_reg, set grant_id, go to ISSUE; ungranted sX_ready SHALL be 0.
REQ-018 ISSUE: m_flt_valid SHALL be 1 and m_flt_data = frame_reg, held stable until m_flt_ready; on transfer go to WAIT and clear the timeout counter.
REQ-019 WAIT: s_flt_ready SHALL be 1; on transfer, latch s_flt_data into result_reg and go to RETURN.
REQ-020 WAIT: the timeout counter SHALL increment each cycle without a result; when it reaches TIMEOUT_CYCLES-1 with no result, pulse timeout_err for one cycle, discard the frame, update last_served, leave frame_count unchanged, go to IDLE.
REQ-021 A result arriving on the same cycle as the timeout SHALL win: go to RETURN, no timeout_err.
REQ-022 RETURN: only m{grant_id}_valid SHALL be 1 with data = result_reg, held until m{grant_id}_ready; on transfer, frame_count += 1 (wraps 0xFFFF -> 0x0000), last_served = grant_id, go to IDLE.
REQ-023 s_flt_ready SHALL be 0 outside WAIT; filter output presented then is ignored and not consumed.
REQ-024 sX_ready SHALL be 0 outside IDLE; new requests wait, with no queueing beyond the single frame_reg.
REQ-025 Minimum latency SHALL be: accept in cycle N, m_flt_valid in N+1; filter result accepted in cycle K, mX_valid in K+1; earliest next accept is the cycle after the mX transfer.
REQ-026 m0_data/m1_data SHALL both drive result_reg; only the valid flags are steered.

Reset
REQ-027 On rst=1 at a clock edge: state=IDLE, all valid/ready outputs 0, busy=0, grant_id=0, frame_count=0, timeout_err=0, last_served=1, timeout counter=0.
REQ-028 Reset mid-transaction (any state) SHALL abandon the frame without a result or timeout_err; frame_reg/result_reg contents are don't-care after reset.

Verification
REQ-029 Single request: s0 sends 0xA5-pattern frame, filter echoes after 10 cycles -> m0_valid with echoed data, m1_valid never high, frame_count=1, busy low after m0 transfer.
REQ-030 Contention: s0_valid and s1_valid held high for 4 frames -> grant order 0,1,0,1; frame_count=4.
REQ-031 Backpressure: m_flt_ready low for 5 cycles in ISSUE, then m0_ready low for 7 cycles in RETURN -> m_flt_data and m0_data stable, frame_count increments once only.
REQ-032 Timeout: TIMEOUT_CYCLES=16, filter never responds -> timeout_err exactly one cycle, 16 cycles after m_flt transfer; state IDLE; frame_count unchanged; next tie granted to the other requester.
REQ-033 Reset in WAIT: assert rst for 1 cycle -> all outputs at reset values next cycle; a late filter result is not consumed (s_flt_ready=0).
REQ-034 Wrap: preload frame_count to 0xFFFF via 65535 transactions (or force) -> next completion yields 0x0000.
